// File: rtl/mem_pkg.sv
// Shared definitions for the memory bank: command encodings, FSM state
// encodings, default geometry and a small op-decode helper.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 4;

  // cmd_op encodings
  localparam logic [1:0] OP_RW    = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RST_CLR = 2'd1;
  localparam logic [1:0] ST_CLR     = 2'd2;

  // Ops that refresh read data and pulse rd_valid
  function automatic logic op_is_read(input logic [1:0] op);
    return (op == OP_RW) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// Clear-sweep address sequencer: counts 0..N_WORDS-1 while active and flags
// the last address so the FSM can leave the sweep after that write.
module mem_clear_seq #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              active,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_last
);

  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Advance while sweeping; park at 0 otherwise so every sweep starts at 0
  always_comb begin
    clr_cnt_d = '0;
    if (active) clr_cnt_d = clr_cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_cnt_q <= '0;
    else        clr_cnt_q <= clr_cnt_d;
  end

  assign clr_addr = clr_cnt_q;
  assign clr_last = active && (&clr_cnt_q);

endmodule

// File: rtl/memory_bank.sv
// Parametrised register/RAM bank: two registered read ports, one write port,
// valid/ready command handshake and a multi-cycle hardware clear sweep.
// Optional feature: define MEMORY_BANK_BYPASS_EN for write-first forwarding
// on OP_RW when a read address matches the write address.
module memory_bank
  import mem_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy
);

  localparam int NPORT = 2;
  localparam int N_WORDS = 2 ** ADDR_W;
  localparam logic [1:0] ST_RESET = CLEAR_ON_RESET ? ST_RST_CLR : ST_IDLE;

  logic [1:0] state_q, state_d;
  logic       rd_valid_q, rd_valid_d;
  logic [NPORT-1:0][DATA_W-1:0] rd_data_q, rd_data_d;

  logic                            accept, sweeping, clr_last;
  logic [ADDR_W-1:0]               clr_addr;
  logic [NPORT-1:0]                rp_en;
  logic [NPORT-1:0][ADDR_W-1:0]    rp_addr;
  logic                            mem_we;
  logic [ADDR_W-1:0]               mem_waddr;
  logic [DATA_W-1:0]               mem_wdata;
  logic [DATA_W-1:0]               mem [N_WORDS];

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = sweeping;
  assign accept    = cmd_valid && cmd_ready;
  assign sweeping  = (state_q == ST_RST_CLR) || (state_q == ST_CLR);

  mem_clear_seq #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (sweeping),
    .clr_addr (clr_addr),
    .clr_last (clr_last)
  );

  // Next state: OP_CLEAR starts a sweep, the last sweep write returns to IDLE
  always_comb begin
    state_d = state_q;
    if (accept && cmd_op == OP_CLEAR) state_d = ST_CLR;
    if (clr_last)                     state_d = ST_IDLE;
  end

  // Array write mux: sweep zeroes have priority (no command accepted then).
  // Held off during reset so an aborted sweep cannot keep writing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (sweeping) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (accept && cmd_op == OP_RW && wr_en) begin
      mem_we = 1'b1;
    end
    if (!rst_n) mem_we = 1'b0;
  end

  // Read ports: port 0 serves OP_RW/OP_READ, port 1 only OP_RW; idle ports hold
  always_comb begin
    rp_en[0]   = accept && op_is_read(cmd_op);
    rp_en[1]   = accept && (cmd_op == OP_RW);
    rp_addr[0] = rd_addr1;
    rp_addr[1] = rd_addr2;
    rd_data_d  = rd_data_q;
    for (int p = 0; p < NPORT; p++) begin
      if (rp_en[p]) begin
        rd_data_d[p] = mem[rp_addr[p]];
`ifdef MEMORY_BANK_BYPASS_EN
        if (cmd_op == OP_RW && wr_en && rp_addr[p] == wr_addr)
          rd_data_d[p] = wr_data;
`endif
      end
    end
    rd_valid_d = accept && op_is_read(cmd_op);
  end

  // Storage array; not touched by rst_n
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RESET;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data1 = rd_data_q[0];
  assign rd_data2 = rd_data_q[1];

endmodule

// File: tb/tb_memory_bank.sv
// Self-checking bench for memory_bank (default build, CLEAR_ON_RESET = 1).
module tb_memory_bank;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NW = 16;
  localparam logic [1:0] OP_RW = 2'b00, OP_CLEAR = 2'b01, OP_READ = 2'b10, OP_NOP = 2'b11;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = OP_NOP;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid, busy;
  logic [DW-1:0] rd_data1, rd_data2;

  int compared = 0, mismatched = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [DW-1:0]   mdl [NW];
  logic [DW-1:0]   last_d2 = '0;

  memory_bank dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_valid(rd_valid),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one command, wait (bounded) for acceptance, push expected read data
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int n;
    logic [DW-1:0] e1, e2;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; rd_addr1 = a1; rd_addr2 = a2;
    wr_en = we; wr_addr = wa; wr_data = wd;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    compared++;
    if (!cmd_ready) begin mismatched++; $display("FAIL send_timeout: cmd_ready=%b want 1", cmd_ready); end
    e1 = mdl[a1]; e2 = (op == OP_RW) ? mdl[a2] : last_d2;
`ifdef MEMORY_BANK_BYPASS_EN
    if (op == OP_RW && we && a1 == wa) e1 = wd;
    if (op == OP_RW && we && a2 == wa) e2 = wd;
`endif
    if (op == OP_RW || op == OP_READ) begin exp_q.push_back({e1, e2}); last_d2 = e2; end
    if (op == OP_RW && we) mdl[wa] = wd;
    if (op == OP_CLEAR) for (int i = 0; i < NW; i++) mdl[i] = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_en = 1'b0;
  endtask

  // Count busy samples at negedges until busy drops (bounded)
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      if (cmd_ready !== 1'b0) begin
        mismatched++; $display("FAIL ready_in_sweep: cmd_ready=%b want 0", cmd_ready);
      end
      cnt++; @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int cnt;
    logic [2*DW-1:0] e;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({busy, cmd_ready, rd_valid, rd_data1, rd_data2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL reset_vals: busy=%b rdy=%b vld=%b d1=%h d2=%h want 1 0 0 0 0",
               busy, cmd_ready, rd_valid, rd_data1, rd_data2);
    end
    rst_n = 1'b1; #1;
    count_busy(cnt);
    compared++;
    if (cnt != NW) begin mismatched++; $display("FAIL reset_sweep_len: got %0d want %0d", cnt, NW); end
    compared++;
    if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_sweep: got %b want 1", cmd_ready); end
    for (int i = 0; i < NW; i++) mdl[i] = '0;
    for (int a = 0; a < NW; a++) begin
      send(OP_READ, AW'(a), '0, 1'b1, AW'(a), 16'hDEAD);  // wr_en must be ignored
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (rd_valid !== 1'b1 || rd_data1 !== e[2*DW-1:DW]) begin
        mismatched++; $display("FAIL reset_read[%0d]: vld=%b d1=%h want 1 %h", a, rd_valid, rd_data1, e[2*DW-1:DW]);
      end
    end
  endtask

  task automatic test_rw;
    logic [2*DW-1:0] e;
    send(OP_RW, 4'd0, 4'd1, 1'b1, 4'd3, 16'h1234);
    @(negedge clk);
    e = exp_q.pop_front();
    compared++;
    if (rd_valid !== 1'b1 || {rd_data1, rd_data2} !== e) begin
      mismatched++; $display("FAIL rw_write: vld=%b d=%h%h want 1 %h", rd_valid, rd_data1, rd_data2, e);
    end
    @(negedge clk);
    compared++;
    if (rd_valid !== 1'b0) begin mismatched++; $display("FAIL rw_pulse: vld=%b want 0", rd_valid); end
    send(OP_READ, 4'd3, 4'd9, 1'b0, '0, '0);
    @(negedge clk);
    e = exp_q.pop_front();
    compared++;
    if (rd_valid !== 1'b1 || rd_data1 !== 16'h1234 || {rd_data1, rd_data2} !== e) begin
      mismatched++; $display("FAIL read_back3: vld=%b d=%h%h want 1 1234 (%h)", rd_valid, rd_data1, rd_data2, e);
    end
  endtask

  task automatic test_dual_read;
    logic [2*DW-1:0] e;
    send(OP_RW, 4'd0, 4'd0, 1'b1, 4'd5, 16'h00AA); @(negedge clk); void'(exp_q.pop_front());
    send(OP_RW, 4'd0, 4'd0, 1'b1, 4'd7, 16'h0055); @(negedge clk); void'(exp_q.pop_front());
    send(OP_RW, 4'd5, 4'd7, 1'b0, '0, '0);
    @(negedge clk);
    e = exp_q.pop_front();
    compared++;
    if (rd_valid !== 1'b1 || {rd_data1, rd_data2} !== 32'h00AA_0055 || e !== 32'h00AA_0055) begin
      mismatched++; $display("FAIL dual_read: vld=%b d=%h_%h want 1 00aa_0055", rd_valid, rd_data1, rd_data2);
    end
    send(OP_NOP, 4'd3, 4'd3, 1'b1, 4'd5, 16'hFFFF);
    @(negedge clk);
    compared++;
    if (rd_valid !== 1'b0 || {rd_data1, rd_data2} !== 32'h00AA_0055) begin
      mismatched++; $display("FAIL nop_hold: vld=%b d=%h_%h want 0 00aa_0055", rd_valid, rd_data1, rd_data2);
    end
    send(OP_READ, 4'd5, 4'd0, 1'b0, '0, '0);  // also proves NOP ignored wr_en
    @(negedge clk);
    e = exp_q.pop_front();
    compared++;
    if ({rd_data1, rd_data2} !== 32'h00AA_0055 || e !== 32'h00AA_0055) begin
      mismatched++; $display("FAIL read_hold_d2: d=%h_%h want 00aa_0055", rd_data1, rd_data2);
    end
  endtask

  task automatic test_same_addr;
    logic [DW-1:0] want;
    send(OP_RW, 4'd0, 4'd0, 1'b1, 4'd2, 16'h1111); @(negedge clk); void'(exp_q.pop_front());
    send(OP_RW, 4'd2, 4'd5, 1'b1, 4'd2, 16'h2222);
    @(negedge clk);
    void'(exp_q.pop_front());
`ifdef MEMORY_BANK_BYPASS_EN
    want = 16'h2222;
`else
    want = 16'h1111;
`endif
    compared++;
    if (rd_valid !== 1'b1 || rd_data1 !== want || rd_data2 !== 16'h00AA) begin
      mismatched++; $display("FAIL same_addr_rw: d1=%h d2=%h want %h 00aa", rd_data1, rd_data2, want);
    end
    send(OP_READ, 4'd2, 4'd0, 1'b0, '0, '0);
    @(negedge clk);
    void'(exp_q.pop_front());
    compared++;
    if (rd_data1 !== 16'h2222) begin mismatched++; $display("FAIL same_addr_later: d1=%h want 2222", rd_data1); end
  endtask

  task automatic test_clear;
    int cnt, vld_seen;
    logic [2*DW-1:0] e;
    for (int a = 0; a < NW; a++) begin
      send(OP_RW, AW'(a), AW'(NW-1-a), 1'b1, AW'(a), 16'hA500 + 16'(a));
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if ({rd_data1, rd_data2} !== e) begin
        mismatched++; $display("FAIL fill[%0d]: d=%h%h want %h", a, rd_data1, rd_data2, e);
      end
    end
    send(OP_CLEAR, '0, '0, 1'b1, 4'd1, 16'hFFFF);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_READ; rd_addr1 = 4'd9;  // offered during sweep
    cnt = 0; vld_seen = 0;
    while (busy && cnt < 100) begin
      if (rd_valid) vld_seen++;
      cnt++; @(negedge clk);
    end
    compared++;
    if (cnt != NW || vld_seen != 0) begin
      mismatched++; $display("FAIL clear_sweep: len=%0d vld=%0d want %0d 0", cnt, vld_seen, NW);
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (rd_valid !== 1'b1 || rd_data1 !== 16'h0000) begin
      mismatched++; $display("FAIL held_cmd: vld=%b d1=%h want 1 0000", rd_valid, rd_data1);
    end
    for (int a = 0; a < NW; a += 2) begin
      send(OP_RW, AW'(a), AW'(a+1), 1'b0, '0, '0);
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if ({rd_data1, rd_data2} !== 32'h0 || e !== 32'h0) begin
        mismatched++; $display("FAIL cleared[%0d]: d=%h%h want 0", a, rd_data1, rd_data2);
      end
    end
  endtask

  task automatic test_reset_mid_sweep;
    int cnt;
    logic [2*DW-1:0] e;
    send(OP_RW, '0, '0, 1'b1, 4'd4, 16'hBEEF); @(negedge clk); void'(exp_q.pop_front());
    send(OP_RW, '0, '0, 1'b1, 4'd15, 16'h7777); @(negedge clk); void'(exp_q.pop_front());
    send(OP_RW, 4'd4, 4'd15, 1'b0, '0, '0);
    @(negedge clk); void'(exp_q.pop_front());
    compared++;
    if ({rd_data1, rd_data2} !== 32'hBEEF_7777) begin
      mismatched++; $display("FAIL pre_abort: d=%h_%h want beef_7777", rd_data1, rd_data2);
    end
    send(OP_CLEAR, '0, '0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0; #1;
    compared++;
    if ({busy, cmd_ready, rd_valid, rd_data1, rd_data2} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL abort_vals: busy=%b rdy=%b vld=%b d1=%h d2=%h want 1 0 0 0 0",
               busy, cmd_ready, rd_valid, rd_data1, rd_data2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    count_busy(cnt);
    compared++;
    if (cnt != NW) begin mismatched++; $display("FAIL restart_len: got %0d want %0d", cnt, NW); end
    for (int i = 0; i < NW; i++) mdl[i] = '0;
    last_d2 = '0;
    send(OP_RW, 4'd15, 4'd4, 1'b0, '0, '0);
    @(negedge clk);
    e = exp_q.pop_front();
    compared++;
    if ({rd_data1, rd_data2} !== 32'h0 || e !== 32'h0) begin
      mismatched++; $display("FAIL restart_cleared: d=%h_%h want 0", rd_data1, rd_data2);
    end
  endtask

  initial begin
    test_reset;
    test_rw;
    test_dual_read;
    test_same_addr;
    test_clear;
    test_reset_mid_sweep;
    compared++;
    if (exp_q.size() != 0) begin mismatched++; $display("FAIL scoreboard_left: %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
Parametrised successor of the Mini-CPU register/RAM bank. It provides N_WORDS words of DATA_W bits, two registered read ports, one write port and a valid/ready command handshake. CLEAR is a multi-cycle hardware sweep instead of a single-cycle reset of the whole array. The bank sits between the instruction decoder (command source) and the ALU (consumer of read data, producer of write data).

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 4, address width; N_WORDS = 2**ADDR_W
CLEAR_ON_RESET, 1, 1 = run a clear sweep automatically after rst_n deasserts; 0 = go straight to IDLE (contents undefined)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  bank can accept a command this cycle
cmd_op  in  2  OP_RW=00, OP_CLEAR=01, OP_READ=10, OP_NOP=11
rd_addr1  in  ADDR_W  read address, port 1
rd_addr2  in  ADDR_W  read address, port 2 (used by OP_RW only)
wr_en  in  1  write enable for OP_RW
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_valid  out  1  one-cycle pulse: rd_data1/rd_data2 updated
rd_data1  out  DATA_W  registered read data, port 1
rd_data2  out  DATA_W  registered read data, port 2
busy  out  1  clear sweep in progress

Behaviour:
- Handshake: a command is accepted on a rising clk edge when cmd_valid && cmd_ready. cmd_ready = (state == IDLE).
- FSM states:
  - RST_CLR: entered from reset when CLEAR_ON_RESET = 1.
  - IDLE.
  - CLR: sweep started by OP_CLEAR.
- Transitions:
  - rst_n low forces RST_CLR (or IDLE when CLEAR_ON_RESET = 0), clr_cnt = 0.
  - IDLE + accepted OP_CLEAR goes to CLR with clr_cnt = 0.
  - RST_CLR/CLR write 0 to mem[clr_cnt] each cycle and increment clr_cnt. When clr_cnt == N_WORDS-1, perform that write, then go to IDLE.
  - Sweep length is exactly N_WORDS cycles; busy is high in those cycles.
- OP_RW:
  - Sample rd_data1 = mem[rd_addr1] and rd_data2 = mem[rd_addr2] (old contents, read-before-write).
  - If wr_en, write mem[wr_addr] = wr_data on the same edge.
  - rd_valid pulses high the following cycle; latency is 1 cycle.
- OP_READ: rd_data1 = mem[rd_addr1]; rd_data2 holds its previous value; rd_valid pulses.
- OP_NOP: accepted, no effect, rd_valid stays low.
- wr_en is ignored for every op other than OP_RW.
- rd_data1/2 hold their values until the next read.
- Reset values: rd_data1 = rd_data2 = 0, rd_valid = 0, busy = CLEAR_ON_RESET, cmd_ready = !CLEAR_ON_RESET. Memory array is not reset by rst_n.
- Reset asserted mid-sweep aborts the sweep. With CLEAR_ON_RESET = 1 the sweep restarts from address 0.
- A cmd_valid held during busy is not accepted; the source keeps the command stable until cmd_ready.
- Same-address read and write in one OP_RW returns the old data (unless the bypass feature is enabled).
- Addresses wrap naturally; no out-of-range case exists.

Optional Feature:
MEMORY_BANK_BYPASS_EN:
- Defined: OP_RW with wr_en and rd_addrN == wr_addr returns wr_data on that port (write-first forwarding).
- Undefined: read-before-write, old data returned.

Decomposition:
- Shared package mem_pkg: cmd_op encodings (OP_RW, OP_CLEAR, OP_READ, OP_NOP), FSM state encodings (ST_IDLE, ST_RST_CLR, ST_CLR), default DATA_W/ADDR_W.
- One natural sub-module, mem_clear_seq: clr_cnt counter plus done flag, driving the sweep write address.

Test Plan:
1. Reset with CLEAR_ON_RESET = 1 -> busy high for 16 cycles, cmd_ready low; then cmd_ready = 1; OP_READ of all 16 addresses returns 0x0000.
2. OP_RW with wr_en, wr_addr = 3, wr_data = 0x1234 -> next cycle rd_valid = 1; OP_READ rd_addr1 = 3 then returns 0x1234 one cycle later.
3. Write 5 -> 0x00AA and 7 -> 0x0055; OP_RW rd_addr1 = 5, rd_addr2 = 7 -> rd_data1 = 0x00AA, rd_data2 = 0x0055, latency 1.
4. Same-address OP_RW: mem[2] = 0x1111, then write 0x2222 to address 2 while reading address 2 -> rd_data1 = 0x1111 without the feature, 0x2222 with MEMORY_BANK_BYPASS_EN; a later read returns 0x2222 in both builds.
5. OP_CLEAR after filling all words -> busy high for 16 cycles, a cmd_valid offered during the sweep is not accepted; afterwards all reads return 0.
6. rst_n pulsed low at sweep cycle 8 -> outputs return to reset values immediately; the sweep restarts at address 0 and lasts a full 16 cycles.
